// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and constants for the I-cache line fill unit
package icache_pkg;

  localparam int LINE_WORDS = 8;
  localparam int IDXW = $clog2(LINE_WORDS);
  localparam logic [31:0] DEADBEEF = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ARM,
    WAIT_HI,
    WRITE,
    DONE
  } fill_state_e;

endpackage

// File: rtl/icache_line_fill_if.sv
// rtl/icache_line_fill_if.sv - miss request, fill write and memory read port bundle
interface icache_line_fill_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int IDXW       = 3
);

  logic                  MISS_REQ;
  logic [ADDR_WIDTH-1:0] MISS_ADDR;
  logic                  BUSY;
  logic                  FILL_WE;
  logic [IDXW-1:0]       FILL_IDX;
  logic [DATA_WIDTH-1:0] FILL_DATA;
  logic                  FILL_DONE;
  logic                  MEM_RDEN1;
  logic [ADDR_WIDTH-1:0] MEM_ADDR1;
  logic [DATA_WIDTH-1:0] MEM_DOUT1;
  logic                  memValid1;

  modport master (
    input  MISS_REQ, MISS_ADDR, MEM_DOUT1, memValid1,
    output BUSY, FILL_WE, FILL_IDX, FILL_DATA, FILL_DONE, MEM_RDEN1, MEM_ADDR1
  );

  modport slave (
    output MISS_REQ, MISS_ADDR, MEM_DOUT1, memValid1,
    input  BUSY, FILL_WE, FILL_IDX, FILL_DATA, FILL_DONE, MEM_RDEN1, MEM_ADDR1
  );

endinterface

// File: rtl/mem_valid_sync.sv
// rtl/mem_valid_sync.sv - tracks memValid1 history, exports its level and a rising-edge pulse
module mem_valid_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_i,
  output logic level_o,
  output logic rise_o
);

  logic valid_q;
  logic valid_d;

  always_comb valid_d = valid_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  assign level_o = valid_i;
  assign rise_o  = valid_i & ~valid_q;

endmodule

// File: rtl/icache_line_fill.sv
// rtl/icache_line_fill.sv - fetches a full I-cache line word by word, paced on memValid1
// ICACHE_CRIT_WORD_FIRST_EN: start the fill at the missing word and wrap through the line.
module icache_line_fill
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = LINE_WORDS
) (
  input logic                 CLK,
  input logic                 RST_N,
  icache_line_fill_if.master  bus
);

  localparam int IDXW_L = $clog2(WORDS_PER_LINE);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(WORDS_PER_LINE - 1);
  localparam logic [IDXW_L-1:0]     LAST_CNT  = IDXW_L'(WORDS_PER_LINE - 1);
`ifdef ICACHE_CRIT_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  fill_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [IDXW_L-1:0]     idx_q, idx_d;
  logic [IDXW_L-1:0]     cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  mem_rden_q, mem_rden_d;
  logic                  valid_lvl, valid_rise;

  mem_valid_sync u_valid_sync (
    .clk     (CLK),
    .rst_n   (RST_N),
    .valid_i (bus.memValid1),
    .level_o (valid_lvl),
    .rise_o  (valid_rise)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      base_q     <= '0;
      mem_addr_q <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      mem_rden_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      mem_addr_q <= mem_addr_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      mem_rden_q <= mem_rden_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    mem_addr_d = mem_addr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    mem_rden_d = mem_rden_q;
    case (state_q)
      IDLE: begin
        if (bus.MISS_REQ) begin
          base_d  = bus.MISS_ADDR & ~LINE_MASK;
          idx_d   = CWF ? bus.MISS_ADDR[IDXW_L-1:0] : '0;
          cnt_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        mem_rden_d = 1'b1;
        mem_addr_d = base_q | {{(ADDR_WIDTH-IDXW_L){1'b0}}, idx_q};
        state_d    = ARM;
      end
      // A low phase seen with the address on the bus guarantees the next high phase carries its data.
      ARM: begin
        if (!valid_lvl) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (valid_rise) begin
          data_d  = bus.MEM_DOUT1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        mem_rden_d = 1'b0;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          idx_d   = idx_q + 1'b1;
          state_d = ADDR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.BUSY      = (state_q != IDLE);
    bus.FILL_WE   = (state_q == WRITE);
    bus.FILL_IDX  = (state_q == WRITE) ? idx_q : '0;
    bus.FILL_DATA = (state_q == WRITE) ? data_q : '0;
    bus.FILL_DONE = (state_q == DONE);
    bus.MEM_RDEN1 = mem_rden_q;
    bus.MEM_ADDR1 = mem_addr_q;
  end

endmodule

// File: tb/tb_icache_line_fill.sv
// tb/tb_icache_line_fill.sv - scoreboard bench for icache_line_fill with a slow-memory model
module tb_icache_line_fill;
  import icache_pkg::*;

  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int WPL = 8;
  localparam int IW  = 3;
`ifdef ICACHE_CRIT_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  typedef struct {
    bit          done;
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  int   line_writes = 0;
  int   done_count = 0;
  bit   post_done = 0;
  logic prev_rden = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  int unsigned vcnt = 0;
  logic [DW-1:0] mem_word = DEADBEEF;

  icache_line_fill_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IDXW(IW)) bus ();

  icache_line_fill #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_LINE(WPL)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.master)
  );

  always #5 CLK = ~CLK;

  // Slow memory: the word for an address is latched during a low phase and shown during the following high phase.
  assign bus.memValid1 = (vcnt < 4);
  assign bus.MEM_DOUT1 = bus.memValid1 ? mem_word : DEADBEEF;
  always @(posedge CLK) begin
    vcnt <= (vcnt + 1) % 8;
    if (!bus.memValid1 && bus.MEM_RDEN1) mem_word <= {18'h0, bus.MEM_ADDR1};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void push_line(input logic [AW-1:0] a);
    int base, start, idx;
    exp_t e;
    base  = int'(a) - (int'(a) % WPL);
    start = CWF ? (int'(a) % WPL) : 0;
    for (int k = 0; k < WPL; k++) begin
      idx    = (start + k) % WPL;
      e.done = 1'b0;
      e.idx  = IW'(idx);
      e.data = DW'(base + idx);
      exp_q.push_back(e);
    end
    e.done = 1'b1;
    e.idx  = '0;
    e.data = '0;
    exp_q.push_back(e);
  endfunction

  always @(negedge CLK) begin
    if (!RST_N) begin
      line_writes = 0;
      post_done   = 0;
      prev_rden   = 1'b0;
    end else begin
      exp_t e;
      if (post_done) begin
        check("busy_low_after_done", bus.BUSY, 0);
        post_done = 0;
      end
      if (bus.FILL_WE && bus.FILL_DONE) check("we_done_overlap", 1, 0);
      if (bus.MEM_RDEN1 && prev_rden) check("mem_addr_stable", bus.MEM_ADDR1, prev_addr);
      prev_rden = bus.MEM_RDEN1;
      prev_addr = bus.MEM_ADDR1;
      if (bus.FILL_WE) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].done) begin
          failures++;
          $display("FAIL unexpected_write actual_idx=%0d actual_data=%h", bus.FILL_IDX, bus.FILL_DATA);
        end else begin
          e = exp_q.pop_front();
          check("fill_idx", bus.FILL_IDX, e.idx);
          check("fill_data", bus.FILL_DATA, e.data);
        end
        line_writes++;
      end
      if (bus.FILL_DONE) begin
        check("writes_per_line", line_writes, WPL);
        checks++;
        if (exp_q.size() == 0 || !exp_q[0].done) begin
          failures++;
          $display("FAIL unexpected_done actual=1 required=0 queued=%0d", exp_q.size());
        end else begin
          void'(exp_q.pop_front());
        end
        done_count++;
        post_done   = 1;
        line_writes = 0;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_busy(input int lim);
    int n = 0;
    while (!bus.BUSY && n < lim) begin
      wait_cycles(1);
      n++;
    end
    check("busy_rise", bus.BUSY, 1);
  endtask

  task automatic wait_done(input int target, input int lim);
    int n = 0;
    while (done_count < target && n < lim) begin
      wait_cycles(1);
      n++;
    end
    check("fill_done_seen", done_count >= target, 1);
  endtask

  task automatic do_fill(input logic [AW-1:0] a, input int nfills, input bit toggle);
    int d0;
    d0 = done_count;
    wait_cycles($urandom_range(0, 7));
    for (int i = 0; i < nfills; i++) push_line(a);
    bus.MISS_ADDR = a;
    bus.MISS_REQ  = 1'b1;
    wait_busy(4);
    if (nfills == 1) begin
      bus.MISS_REQ = 1'b0;
      if (toggle) begin
        for (int i = 0; i < 20; i++) begin
          wait_cycles(1);
          bus.MISS_REQ  = 1'($urandom);
          bus.MISS_ADDR = AW'($urandom);
        end
        bus.MISS_REQ = 1'b0;
      end
      wait_done(d0 + 1, 400);
    end else begin
      wait_done(d0 + 1, 400);
      wait_busy(4);
      bus.MISS_REQ = 1'b0;
      wait_done(d0 + 2, 400);
    end
    wait_cycles(2);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {bus.BUSY, bus.FILL_WE, bus.FILL_IDX, bus.FILL_DATA, bus.FILL_DONE,
                 bus.MEM_RDEN1, bus.MEM_ADDR1}, 64'd0);
  endtask

  initial begin
    int d0;
    int n;
    RST_N         = 1'b0;
    bus.MISS_REQ  = 1'b0;
    bus.MISS_ADDR = '0;
    wait_cycles(3);
    check_outputs_zero("reset_outputs");
    RST_N = 1'b1;
    wait_cycles(2);

    do_fill(14'h0013, 1, 0);
    do_fill(14'h0013, 1, 1);
    for (int i = 0; i < 4; i++) do_fill(AW'($urandom), 1, 1'($urandom));

    // Abandon a fill mid-line; the remaining words and its done pulse must never appear.
    d0 = done_count;
    push_line(14'h0013);
    bus.MISS_ADDR = 14'h0013;
    bus.MISS_REQ  = 1'b1;
    wait_busy(4);
    bus.MISS_REQ = 1'b0;
    n = 0;
    while (line_writes < 4 && n < 200) begin
      wait_cycles(1);
      n++;
    end
    check("reached_word4", line_writes, 4);
    RST_N = 1'b0;
    #1;
    check_outputs_zero("async_reset_outputs");
    exp_q.delete();
    wait_cycles(3);
    RST_N = 1'b1;
    wait_cycles(2);
    check("no_done_on_reset", done_count, d0);
    do_fill(14'h3FF8, 1, 0);
    do_fill(14'h3FFD, 1, 0);

    do_fill(14'h0020, 2, 0);
    do_fill(AW'($urandom), 2, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
